// File: rtl/iir_biquad_mc_if.sv
// Handshake bundle for iir_biquad_mc.
// Carries the coefficient-load port, the state-clear strobe, the sample input
// (vIn/chIn/dIn) and the filtered output (vOut/chOut/dOut/ovf).
//   master : the source/controller side (drives config and samples, reads results)
//   slave  : the filter side
interface iir_biquad_mc_if #(
  parameter int NB = 12,
  parameter int CW = 2
);
  logic            cfgWr;
  logic [3*NB-1:0] bIn;
  logic [2*NB-1:0] aIn;
  logic            clrSt;
  logic            vIn;
  logic [CW-1:0]   chIn;
  logic [NB-1:0]   dIn;
  logic            vOut;
  logic [CW-1:0]   chOut;
  logic [NB-1:0]   dOut;
  logic            ovf;

  modport master (
    output cfgWr, bIn, aIn, clrSt, vIn, chIn, dIn,
    input  vOut, chOut, dOut, ovf
  );

  modport slave (
    input  cfgWr, bIn, aIn, clrSt, vIn, chIn, dIn,
    output vOut, chOut, dOut, ovf
  );
endinterface

// File: rtl/iir_biquad_mc.sv
// Multichannel direct-form-I biquad with one shared MAC datapath.
// Each accepted sample on channel c is filtered with that channel's own
// x1/x2/y1/y2 history and the shared runtime-loaded coefficients; the result
// is registered one cycle later together with its channel tag and an
// overflow flag (saturate or wrap selected by SAT).
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (outputs, state and coefficients)
//   bus  slave side of iir_biquad_mc_if: cfgWr/bIn/aIn coefficient load,
//        clrSt state clear, vIn/chIn/dIn sample in, vOut/chOut/dOut/ovf out
module iir_biquad_mc #(
  parameter int NB  = 12,
  parameter int CF  = 10,
  parameter int NCH = 4,
  parameter bit SAT = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  iir_biquad_mc_if.slave      bus
);
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int ACC = 2 * NB + 3;

  localparam logic [CW:0]             NCH_L   = (CW + 1)'(NCH);
  // Rounding constant 2^(CF-1) at accumulator width
  localparam logic signed [ACC-1:0]   HALF_L  = {{(ACC-CF){1'b0}}, 1'b1, {(CF-1){1'b0}}};
  localparam logic signed [ACC-1:0]   MAX_L   = {{(ACC-NB+1){1'b0}}, {(NB-1){1'b1}}};
  localparam logic signed [ACC-1:0]   MIN_L   = {{(ACC-NB+1){1'b1}}, {(NB-1){1'b0}}};
  localparam logic signed [NB-1:0]    SAT_HI  = {1'b0, {(NB-1){1'b1}}};
  localparam logic signed [NB-1:0]    SAT_LO  = {1'b1, {(NB-1){1'b0}}};
  // Identity b0 = 1.0 in Q(CF)
  localparam logic signed [NB-1:0]    ONE_L   = {{(NB-CF-1){1'b0}}, 1'b1, {CF{1'b0}}};
  localparam logic signed [NB-1:0]    ZERO_L  = {NB{1'b0}};

  // Coefficient registers
  logic signed [NB-1:0] b0_r, b1_r, b2_r, a1_r, a2_r;

  // Per-channel history
  logic signed [NB-1:0] x1_r [NCH];
  logic signed [NB-1:0] x2_r [NCH];
  logic signed [NB-1:0] y1_r [NCH];
  logic signed [NB-1:0] y2_r [NCH];

  // Output registers
  logic                 vout_r;
  logic [CW-1:0]        chout_r;
  logic [NB-1:0]        dout_r;
  logic                 ovf_r;

  // Datapath signals
  logic [CW-1:0]         ch_s;
  logic                  accept_s;
  logic signed [NB-1:0]  x_s, x1_s, x2_s, y1_s, y2_s;
  logic signed [2*NB-1:0] p_b0_s, p_b1_s, p_b2_s, p_a1_s, p_a2_s;
  logic signed [ACC-1:0] acc_s, rnd_s, r_s;
  logic                  ovf_s;
  logic signed [NB-1:0]  y_s;

  // Shared MAC: select channel history, multiply-accumulate, round, limit
  always_comb begin
    ch_s     = bus.chIn;
    accept_s = bus.vIn && ({1'b0, ch_s} < NCH_L);
    x_s      = $signed(bus.dIn);
    // A simultaneous clear makes this sample see an all-zero history
    if (bus.clrSt) begin
      x1_s = ZERO_L;
      x2_s = ZERO_L;
      y1_s = ZERO_L;
      y2_s = ZERO_L;
    end else begin
      x1_s = x1_r[ch_s];
      x2_s = x2_r[ch_s];
      y1_s = y1_r[ch_s];
      y2_s = y2_r[ch_s];
    end
    p_b0_s = b0_r * x_s;
    p_b1_s = b1_r * x1_s;
    p_b2_s = b2_r * x2_s;
    p_a1_s = a1_r * y1_s;
    p_a2_s = a2_r * y2_s;
    acc_s  = ACC'(p_b0_s) + ACC'(p_b1_s) + ACC'(p_b2_s) - ACC'(p_a1_s) - ACC'(p_a2_s);
    rnd_s  = acc_s + HALF_L;
    r_s    = rnd_s >>> CF;
    ovf_s  = (r_s > MAX_L) || (r_s < MIN_L);
    if (SAT) begin
      if (r_s > MAX_L) begin
        y_s = SAT_HI;
      end else if (r_s < MIN_L) begin
        y_s = SAT_LO;
      end else begin
        y_s = r_s[NB-1:0];
      end
    end else begin
      y_s = r_s[NB-1:0];
    end
  end

  // Coefficients, channel history and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      b0_r    <= ONE_L;
      b1_r    <= ZERO_L;
      b2_r    <= ZERO_L;
      a1_r    <= ZERO_L;
      a2_r    <= ZERO_L;
      vout_r  <= 1'b0;
      chout_r <= {CW{1'b0}};
      dout_r  <= {NB{1'b0}};
      ovf_r   <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        x1_r[i] <= ZERO_L;
        x2_r[i] <= ZERO_L;
        y1_r[i] <= ZERO_L;
        y2_r[i] <= ZERO_L;
      end
    end else begin
      // New coefficients only affect samples from the next cycle on
      if (bus.cfgWr) begin
        b0_r <= $signed(bus.bIn[NB-1:0]);
        b1_r <= $signed(bus.bIn[2*NB-1:NB]);
        b2_r <= $signed(bus.bIn[3*NB-1:2*NB]);
        a1_r <= $signed(bus.aIn[NB-1:0]);
        a2_r <= $signed(bus.aIn[2*NB-1:NB]);
      end
      // Clear first; the channel update below wins for the accepted channel
      if (bus.clrSt) begin
        for (int i = 0; i < NCH; i++) begin
          x1_r[i] <= ZERO_L;
          x2_r[i] <= ZERO_L;
          y1_r[i] <= ZERO_L;
          y2_r[i] <= ZERO_L;
        end
      end
      vout_r <= accept_s;
      if (accept_s) begin
        chout_r     <= ch_s;
        dout_r      <= y_s;
        ovf_r       <= ovf_s;
        x2_r[ch_s]  <= x1_s;
        x1_r[ch_s]  <= x_s;
        y2_r[ch_s]  <= y1_s;
        y1_r[ch_s]  <= y_s;
      end
    end
  end

  assign bus.vOut  = vout_r;
  assign bus.chOut = chout_r;
  assign bus.dOut  = dout_r;
  assign bus.ovf   = ovf_r;
endmodule
